// File: rtl/digital_lock_pkg.sv
// Shared state encoding and digit-select helper for the digital_lock_seq code lock.
package digital_lock_pkg;

   localparam logic [1:0] ST_ENTRY    = 2'd0;
   localparam logic [1:0] ST_UNLOCKED = 2'd1;
   localparam logic [1:0] ST_LOCKOUT  = 2'd2;
   localparam logic [1:0] ST_PROG     = 2'd3;

   localparam int unsigned MAX_CODE_W  = 256;
   localparam int unsigned MAX_DIGIT_W = 32;

   // Digit idx of a code vector; digit 0 is the most significant (entered first).
   function automatic logic [MAX_DIGIT_W-1:0] code_digit(
      input logic [MAX_CODE_W-1:0] code,
      input int unsigned           idx,
      input int unsigned           digit_w,
      input int unsigned           code_len
   );
      logic [MAX_CODE_W-1:0]  shifted;
      logic [MAX_DIGIT_W-1:0] mask;
      shifted = code >> ((code_len - 32'd1 - idx) * digit_w);
      if (digit_w >= MAX_DIGIT_W) begin
         mask = {MAX_DIGIT_W{1'b1}};
      end else begin
         mask = (32'd1 << digit_w) - 32'd1;
      end
      return shifted[MAX_DIGIT_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/digital_lock_seq_counter.sv
// lock_down_counter: loadable, saturating down-counter with a zero flag (lockout timer).
module lock_down_counter #(
   parameter int unsigned W = 10
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load has priority; decrement stops at zero so the count never wraps.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != {W{1'b0}})) begin
         count_d = count_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/digital_lock_seq.sv
// digital_lock_seq: multi-digit code lock with try limit and timed lockout.
// Optional code reprogramming is compiled in with the PROG_CODE_EN macro.
module digital_lock_seq
   import digital_lock_pkg::*;
#(
   parameter int unsigned DIGIT_W        = 4,
   parameter int unsigned CODE_LEN       = 4,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'hA5C3
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              digit_valid,
   input  logic [DIGIT_W-1:0]                digit,
   input  logic                              clear,
   input  logic                              relock,
   input  logic                              prog_start,
   output logic                              unlocked,
   output logic                              locked_out,
   output logic                              fail_pulse,
   output logic                              prog_done,
   output logic [$clog2(MAX_TRIES+1)-1:0]    attempts_left,
   output logic [$clog2(CODE_LEN+1)-1:0]     digits_entered
);

   localparam int unsigned AW = $clog2(MAX_TRIES + 1);
   localparam int unsigned DW = $clog2(CODE_LEN + 1);
   localparam int unsigned CW = CODE_LEN * DIGIT_W;
   localparam int unsigned TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [AW-1:0] TRIES_MAX = AW'(MAX_TRIES);
   localparam logic [AW-1:0] ONE_TRY   = AW'(32'd1);
   localparam logic [DW-1:0] LAST_IDX  = DW'(CODE_LEN - 1);
   localparam logic [DW-1:0] ONE_DIGIT = DW'(32'd1);
   localparam logic [TW-1:0] TMR_LOAD  = TW'(LOCKOUT_CYCLES - 1);

   logic [1:0]         state_q, state_d;
   logic [AW-1:0]      attempts_q, attempts_d;
   logic [DW-1:0]      digits_q, digits_d;
   logic               flag_q, flag_d;
   logic               fail_q, fail_d;
   logic               prog_done_q, prog_done_d;
   logic               unlocked_q, unlocked_d;
   logic               locked_out_q, locked_out_d;
   logic               tmr_load_s, tmr_en_s, tmr_zero_s;
   logic [CW-1:0]      code_s;
   logic [DIGIT_W-1:0] exp_digit_s;
   logic               mismatch_s;
   logic               last_s;

`ifdef PROG_CODE_EN
   logic [CW-1:0] code_q, code_d;
   logic [CW-1:0] shadow_q, shadow_d;

   // Programmable code and the shadow register collecting a new code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code_q   <= DEFAULT_CODE;
         shadow_q <= {CW{1'b0}};
      end else begin
         code_q   <= code_d;
         shadow_q <= shadow_d;
      end
   end

   assign code_s = code_q;
`else
   assign code_s = DEFAULT_CODE;
`endif

   assign exp_digit_s = DIGIT_W'(code_digit(MAX_CODE_W'(code_s), 32'(digits_q), DIGIT_W, CODE_LEN));
   assign mismatch_s  = flag_q | (digit != exp_digit_s);
   assign last_s      = (digits_q == LAST_IDX);

   lock_down_counter #(.W(TW)) u_lockout_tmr (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_s),
      .en       (tmr_en_s),
      .load_val (TMR_LOAD),
      .zero     (tmr_zero_s)
   );

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ENTRY;
         attempts_q   <= TRIES_MAX;
         digits_q     <= {DW{1'b0}};
         flag_q       <= 1'b0;
         fail_q       <= 1'b0;
         prog_done_q  <= 1'b0;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         attempts_q   <= attempts_d;
         digits_q     <= digits_d;
         flag_q       <= flag_d;
         fail_q       <= fail_d;
         prog_done_q  <= prog_done_d;
         unlocked_q   <= unlocked_d;
         locked_out_q <= locked_out_d;
      end
   end

   // Next-state logic; the verdict is only given once all digits are in.
   always_comb begin
      state_d     = state_q;
      attempts_d  = attempts_q;
      digits_d    = digits_q;
      flag_d      = flag_q;
      fail_d      = 1'b0;
      prog_done_d = 1'b0;
      tmr_load_s  = 1'b0;
      tmr_en_s    = 1'b0;
`ifdef PROG_CODE_EN
      code_d      = code_q;
      shadow_d    = shadow_q;
`endif
      case (state_q)
         ST_ENTRY: begin
            if (clear) begin
               digits_d = {DW{1'b0}};
               flag_d   = 1'b0;
            end else if (digit_valid) begin
               if (last_s) begin
                  digits_d = {DW{1'b0}};
                  flag_d   = 1'b0;
                  if (!mismatch_s) begin
                     state_d    = ST_UNLOCKED;
                     attempts_d = TRIES_MAX;
                  end else if (attempts_q > ONE_TRY) begin
                     attempts_d = attempts_q - ONE_TRY;
                     fail_d     = 1'b1;
                  end else begin
                     state_d    = ST_LOCKOUT;
                     attempts_d = {AW{1'b0}};
                     fail_d     = 1'b1;
                     tmr_load_s = 1'b1;
                  end
               end else begin
                  digits_d = digits_q + ONE_DIGIT;
                  flag_d   = mismatch_s;
               end
            end else begin
               digits_d = digits_q;
            end
         end
         ST_UNLOCKED: begin
            if (relock) begin
               state_d    = ST_ENTRY;
               attempts_d = TRIES_MAX;
               digits_d   = {DW{1'b0}};
            end else if (prog_start) begin
`ifdef PROG_CODE_EN
               state_d  = ST_PROG;
               digits_d = {DW{1'b0}};
               shadow_d = {CW{1'b0}};
`else
               state_d  = ST_UNLOCKED;
`endif
            end else begin
               state_d = ST_UNLOCKED;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_zero_s) begin
               state_d    = ST_ENTRY;
               attempts_d = TRIES_MAX;
            end else begin
               tmr_en_s = 1'b1;
            end
         end
`ifdef PROG_CODE_EN
         ST_PROG: begin
            if (relock) begin
               state_d    = ST_ENTRY;
               attempts_d = TRIES_MAX;
               digits_d   = {DW{1'b0}};
            end else if (clear) begin
               state_d  = ST_UNLOCKED;
               digits_d = {DW{1'b0}};
            end else if (digit_valid) begin
               shadow_d = (shadow_q << DIGIT_W) | CW'(digit);
               if (last_s) begin
                  code_d      = shadow_d;
                  prog_done_d = 1'b1;
                  state_d     = ST_UNLOCKED;
                  digits_d    = {DW{1'b0}};
               end else begin
                  digits_d = digits_q + ONE_DIGIT;
               end
            end else begin
               state_d = ST_PROG;
            end
         end
`endif
         default: begin
            state_d    = ST_ENTRY;
            attempts_d = TRIES_MAX;
            digits_d   = {DW{1'b0}};
            flag_d     = 1'b0;
         end
      endcase
   end

   // Level outputs follow the next state so they register with it.
   always_comb begin
      unlocked_d   = (state_d == ST_UNLOCKED) || (state_d == ST_PROG);
      locked_out_d = (state_d == ST_LOCKOUT);
   end

   assign unlocked       = unlocked_q;
   assign locked_out     = locked_out_q;
   assign fail_pulse     = fail_q;
   assign prog_done      = prog_done_q;
   assign attempts_left  = attempts_q;
   assign digits_entered = digits_q;

endmodule
